// File: rtl/cpu_run_pkg.sv
// Shared types and default constants for the CPU run controller.
package cpu_run_pkg;

   localparam int unsigned DEF_PC_WIDTH     = 32;
   localparam int unsigned DEF_CNT_WIDTH    = 32;
   localparam int unsigned DEF_RESET_CYCLES = 4;
   localparam int unsigned DEF_MAX_CYCLES   = 125;
   localparam int unsigned DEF_STALL_LIMIT  = 8;
   localparam logic [31:0] DEF_HALT_ADDR    = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      RUN,
      FINISH
   } run_state_t;

   // Why a run ended; consumed by monitors and scoreboards.
   typedef enum logic [1:0] {
      END_NONE,
      END_HALT_ADDR,
      END_STALL,
      END_TIMEOUT
   } end_cause_t;

endpackage

// File: rtl/cpu_run_controller_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/cpu_run_controller.sv
// Run control for the pipelined core: timed core reset, supervised run,
// and end-of-run detection by halt address, PC stall or cycle budget.
module cpu_run_controller
   import cpu_run_pkg::*;
#(
   parameter int unsigned          PC_WIDTH     = DEF_PC_WIDTH,
   parameter int unsigned          CNT_WIDTH    = DEF_CNT_WIDTH,
   parameter int unsigned          RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int unsigned          MAX_CYCLES   = DEF_MAX_CYCLES,
   parameter logic [PC_WIDTH-1:0]  HALT_ADDR    = PC_WIDTH'(DEF_HALT_ADDR),
   parameter int unsigned          STALL_LIMIT  = DEF_STALL_LIMIT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [PC_WIDTH-1:0]  pc,
   input  logic                 retire_valid,
   output logic                 core_reset,
   output logic                 running,
   output logic                 done,
   output logic                 halted,
   output logic                 timed_out,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] retire_count
);

   localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   run_state_t            state, state_next;
   logic [HOLD_W-1:0]     hold_cnt, hold_next;
   logic [PC_WIDTH-1:0]   prev_pc;
   logic [CNT_WIDTH-1:0]  stall_cnt;
   logic                  done_next, halted_next, timed_out_next;
   logic                  cnt_clear, cycle_en, retire_en, stall_en, stall_clear;
   logic                  pc_same, halt_hit, stall_hit, timeout_hit;

   assign pc_same     = (pc == prev_pc);
   assign halt_hit    = (pc == HALT_ADDR);
   // Stall fires on the cycle the counter would reach the limit.
   assign stall_hit   = (STALL_LIMIT != 0) && pc_same &&
                        (stall_cnt == CNT_WIDTH'(STALL_LIMIT - 1));
   assign timeout_hit = (cycle_count == CNT_WIDTH'(MAX_CYCLES - 1));

   // Next-state and control decode.
   always_comb begin
      state_next     = state;
      hold_next      = hold_cnt;
      done_next      = done;
      halted_next    = halted;
      timed_out_next = timed_out;
      cnt_clear      = 1'b0;
      cycle_en       = 1'b0;
      retire_en      = 1'b0;
      stall_en       = 1'b0;
      stall_clear    = 1'b0;
      unique case (state)
         IDLE, FINISH: begin
            if (start) begin
               state_next     = HOLD;
               hold_next      = HOLD_W'(RESET_CYCLES - 1);
               done_next      = 1'b0;
               halted_next    = 1'b0;
               timed_out_next = 1'b0;
               cnt_clear      = 1'b1;
               stall_clear    = 1'b1;
            end
         end
         HOLD: begin
            if (hold_cnt == '0) begin
               state_next = RUN;
            end else begin
               hold_next = hold_cnt - HOLD_W'(1);
            end
         end
         RUN: begin
            cycle_en    = 1'b1;
            retire_en   = retire_valid;
            stall_en    = pc_same;
            stall_clear = !pc_same;
            if (halt_hit || stall_hit) begin
               state_next  = FINISH;
               done_next   = 1'b1;
               halted_next = 1'b1;
            end else if (timeout_hit) begin
               state_next     = FINISH;
               done_next      = 1'b1;
               timed_out_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         prev_pc    <= '0;
         core_reset <= 1'b1;
         running    <= 1'b0;
         done       <= 1'b0;
         halted     <= 1'b0;
         timed_out  <= 1'b0;
      end else begin
         state      <= state_next;
         hold_cnt   <= hold_next;
         if ((state == HOLD) || (state == RUN)) begin
            prev_pc <= pc;
         end
         core_reset <= (state_next != RUN);
         running    <= (state_next == RUN);
         done       <= done_next;
         halted     <= halted_next;
         timed_out  <= timed_out_next;
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cycle_en),
      .count  (cycle_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_retire_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (retire_en),
      .count  (retire_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (stall_clear),
      .enable (stall_en),
      .count  (stall_cnt)
   );

endmodule
